ntr_cmd_dispatch: RTL and testbench



---
 rtl/ntr_cmd_dispatch.sv | 150 +++++++++++++++
 tb/tb_ntr_cmd_dispatch.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ntr_cmd_dispatch.sv
// NTR command execution stage: latches a decoded command, executes its opcode and
// hands one 32-bit response word per serializer request, streaming 0xB7 reads from ROM.
module ntr_cmd_dispatch #(
  parameter int          ADDR_W      = 10,
  parameter int          BLOCK_WORDS = 128,
  parameter logic [31:0] CHIP_ID     = 32'h807F01E0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [63:0]       command,
  input  logic              ready,
  input  logic              request_word,
  output logic [31:0]       data_word,
  output logic              word_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [31:0]       mem_rdata,
  output logic              led,
  output logic              underrun
);

  localparam int CNT_W = $clog2(BLOCK_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_FETCH,
    S_WAIT,
    S_SERVE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [63:0]       r_cmd;
  logic [CNT_W-1:0]  r_count;
  logic [31:0]       r_dataWord;
  logic              r_wordValid;
  logic [ADDR_W-1:0] r_memAddr;
  logic              r_led;
  logic              r_underrun;

  logic [31:0] w_byteAddr;
  logic        w_isBlock;
  logic        w_lastWord;
  logic        w_unused;

  // Byte address is big-endian across command bytes 1..4.
  assign w_byteAddr = {r_cmd[15:8], r_cmd[23:16], r_cmd[31:24], r_cmd[39:32]};
  assign w_isBlock  = (r_cmd[7:0] == 8'hB7);
  assign w_lastWord = (r_count == CNT_W'(BLOCK_WORDS - 1));
  assign w_unused   = ^{r_cmd[63:57], r_cmd[55:40], w_byteAddr};

  assign data_word  = r_dataWord;
  assign word_valid = r_wordValid;
  assign mem_addr   = r_memAddr;
  assign mem_rd     = (r_state == S_FETCH);
  assign led        = r_led;
  assign underrun   = r_underrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_count     <= '0;
      r_dataWord  <= '0;
      r_wordValid <= 1'b0;
      r_memAddr   <= '0;
      r_led       <= 1'b0;
      r_underrun  <= 1'b0;
    end else if (r_state != S_IDLE && !ready) begin
      // Abort beats any simultaneous request; an in-flight ROM word is simply dropped.
      r_state     <= S_IDLE;
      r_wordValid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ready) begin
            r_cmd      <= command;
            r_count    <= '0;
            r_underrun <= 1'b0;
            r_state    <= S_DECODE;
          end else if (request_word) begin
            r_underrun <= 1'b1;
          end
        end
        S_DECODE: begin
          if (request_word) r_underrun <= 1'b1;
          case (r_cmd[7:0])
            8'hFF: begin
              r_led       <= r_cmd[56];
              r_dataWord  <= 32'h0000_0001;
              r_wordValid <= 1'b1;
              r_state     <= S_SERVE;
            end
            8'h90: begin
              r_dataWord  <= CHIP_ID;
              r_wordValid <= 1'b1;
              r_state     <= S_SERVE;
            end
            8'h9F: begin
              r_dataWord  <= 32'hFFFF_FFFF;
              r_wordValid <= 1'b1;
              r_state     <= S_SERVE;
            end
            8'hB7: begin
              r_memAddr <= w_byteAddr[ADDR_W+1:2];
              r_state   <= S_FETCH;
            end
            default: begin
              r_dataWord  <= '0;
              r_wordValid <= 1'b1;
              r_state     <= S_SERVE;
            end
          endcase
        end
        S_FETCH: begin
          if (request_word) r_underrun <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (request_word) r_underrun <= 1'b1;
          r_dataWord  <= mem_rdata;
          r_wordValid <= 1'b1;
          r_state     <= S_SERVE;
        end
        S_SERVE: begin
          if (request_word) begin
            if (!w_isBlock) begin
              if (r_count != '1) r_count <= r_count + CNT_W'(1);
            end else if (w_lastWord) begin
              r_dataWord <= 32'hFFFF_FFFF;
              r_state    <= S_DONE;
            end else begin
              r_wordValid <= 1'b0;
              r_count     <= r_count + CNT_W'(1);
              r_memAddr   <= r_memAddr + ADDR_W'(1);
              r_state     <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          r_dataWord  <= 32'hFFFF_FFFF;
          r_wordValid <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntr_cmd_dispatch.sv
// Directed bench for ntr_cmd_dispatch with a small block size and a ROM holding ROM[i]=i.
module tb_ntr_cmd_dispatch;

  localparam int ADDR_W      = 10;
  localparam int BLOCK_WORDS = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [63:0]       command;
  logic              ready;
  logic              request_word;
  logic [31:0]       data_word;
  logic              word_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [31:0]       mem_rdata = '0;
  logic              led;
  logic              underrun;

  int compared   = 0;
  int mismatched = 0;
  int rdCount    = 0;

  ntr_cmd_dispatch #(
    .ADDR_W(ADDR_W),
    .BLOCK_WORDS(BLOCK_WORDS),
    .CHIP_ID(32'h807F01E0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .command(command),
    .ready(ready),
    .request_word(request_word),
    .data_word(data_word),
    .word_valid(word_valid),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_rdata(mem_rdata),
    .led(led),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Synchronous ROM whose contents equal the word address.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= 32'(mem_addr);
    if (!rst && mem_rd) rdCount++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] cmd, input logic rdy, input logic req);
    command      = cmd;
    ready        = rdy;
    request_word = req;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request pulse followed by four quiet cycles (5-cycle spacing).
  task automatic requestWord(input logic [63:0] cmd);
    applyStimulus(cmd, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(cmd, 1'b1, 1'b0);
  endtask

  initial begin
    logic [63:0] cmdB7a;
    logic [63:0] cmdB7w;
    cmdB7a = 64'h0000_0008_0000_00B7;
    cmdB7w = 64'h0000_00FC_0F00_00B7;

    rst = 1'b1; command = '0; ready = 1'b0; request_word = 1'b0;
    tick();
    tick();
    checkOutput("rst_data", data_word, 32'h0);
    checkOutput("rst_valid", 32'(word_valid), 32'h0);
    checkOutput("rst_addr", 32'(mem_addr), 32'h0);
    checkOutput("rst_rd", 32'(mem_rd), 32'h0);
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_underrun", 32'(underrun), 32'h0);
    rst = 1'b0;

    applyStimulus(64'h90, 1'b1, 1'b0);
    checkOutput("id_k_valid", 32'(word_valid), 32'h0);
    applyStimulus(64'h90, 1'b1, 1'b0);
    checkOutput("id_valid", 32'(word_valid), 32'h1);
    checkOutput("id_data", data_word, 32'h807F01E0);
    applyStimulus(64'h90, 1'b1, 1'b1);
    applyStimulus(64'h90, 1'b1, 1'b0);
    checkOutput("id_repeat", data_word, 32'h807F01E0);
    checkOutput("id_repeat_valid", 32'(word_valid), 32'h1);
    applyStimulus(64'h90, 1'b0, 1'b0);
    checkOutput("id_abort_valid", 32'(word_valid), 32'h0);
    checkOutput("id_abort_hold", data_word, 32'h807F01E0);

    applyStimulus(64'h0100_0000_0000_00FF, 1'b1, 1'b0);
    applyStimulus(64'h0100_0000_0000_00FF, 1'b1, 1'b0);
    checkOutput("led_on", 32'(led), 32'h1);
    checkOutput("led_on_data", data_word, 32'h1);
    applyStimulus(64'h0, 1'b0, 1'b0);
    checkOutput("led_hold_on", 32'(led), 32'h1);
    applyStimulus(64'hFF, 1'b1, 1'b0);
    applyStimulus(64'hFF, 1'b1, 1'b0);
    checkOutput("led_off", 32'(led), 32'h0);
    applyStimulus(64'h0, 1'b0, 1'b0);
    checkOutput("led_hold_off", 32'(led), 32'h0);

    rdCount = 0;
    applyStimulus(cmdB7a, 1'b1, 1'b0);
    applyStimulus(cmdB7a, 1'b1, 1'b0);
    checkOutput("b7_addr", 32'(mem_addr), 32'h2);
    checkOutput("b7_rd", 32'(mem_rd), 32'h1);
    applyStimulus(cmdB7a, 1'b1, 1'b0);
    checkOutput("b7_k2_valid", 32'(word_valid), 32'h0);
    applyStimulus(cmdB7a, 1'b1, 1'b0);
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      checkOutput($sformatf("b7_word%0d", w), data_word, 32'(2 + w));
      checkOutput($sformatf("b7_valid%0d", w), 32'(word_valid), 32'h1);
      requestWord(cmdB7a);
    end
    checkOutput("b7_pad", data_word, 32'hFFFF_FFFF);
    checkOutput("b7_pad_valid", 32'(word_valid), 32'h1);
    requestWord(cmdB7a);
    checkOutput("b7_done_repeat", data_word, 32'hFFFF_FFFF);
    checkOutput("b7_rd_count", 32'(rdCount), 32'(BLOCK_WORDS));
    checkOutput("b7_no_underrun", 32'(underrun), 32'h0);
    applyStimulus(cmdB7a, 1'b0, 1'b0);

    applyStimulus(cmdB7w, 1'b1, 1'b0);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    checkOutput("wrap_addr", 32'(mem_addr), 32'h3FF);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    checkOutput("wrap_top", data_word, 32'h3FF);
    applyStimulus(cmdB7w, 1'b1, 1'b1);
    checkOutput("wrap_fetch_valid", 32'(word_valid), 32'h0);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    applyStimulus(cmdB7w, 1'b1, 1'b1);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    checkOutput("ur_set", 32'(underrun), 32'h1);
    checkOutput("wrap_zero", data_word, 32'h0);
    checkOutput("wrap_zero_addr", 32'(mem_addr), 32'h0);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    applyStimulus(cmdB7w, 1'b1, 1'b0);
    requestWord(cmdB7w);
    checkOutput("ur_no_skip1", data_word, 32'h1);
    requestWord(cmdB7w);
    checkOutput("ur_no_skip2", data_word, 32'h2);
    requestWord(cmdB7w);
    checkOutput("ur_count_kept", data_word, 32'hFFFF_FFFF);
    applyStimulus(cmdB7w, 1'b0, 1'b0);
    checkOutput("ur_sticky", 32'(underrun), 32'h1);

    applyStimulus(cmdB7a, 1'b1, 1'b0);
    checkOutput("ur_clear", 32'(underrun), 32'h0);
    applyStimulus(cmdB7a, 1'b1, 1'b0);
    applyStimulus(cmdB7a, 1'b1, 1'b0);
    applyStimulus(cmdB7a, 1'b0, 1'b1);
    checkOutput("abort_valid", 32'(word_valid), 32'h0);
    checkOutput("abort_no_ur", 32'(underrun), 32'h0);
    checkOutput("abort_hold", data_word, 32'hFFFF_FFFF);
    applyStimulus(cmdB7a, 1'b0, 1'b0);
    checkOutput("abort_idle_rd", 32'(mem_rd), 32'h0);
    checkOutput("abort_idle_valid", 32'(word_valid), 32'h0);
    applyStimulus(64'h9F, 1'b1, 1'b0);
    applyStimulus(64'h9F, 1'b1, 1'b0);
    checkOutput("9f_data", data_word, 32'hFFFF_FFFF);
    checkOutput("9f_valid", 32'(word_valid), 32'h1);

    rst = 1'b1;
    applyStimulus(64'h9F, 1'b1, 1'b0);
    checkOutput("midrst_valid", 32'(word_valid), 32'h0);
    checkOutput("midrst_data", data_word, 32'h0);
    rst = 1'b0;
    applyStimulus(64'h0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
